// File: rtl/sw_debounce_24.sv
// Switch input conditioner: two-flop synchroniser, prescaled sampling and a
// whole-vector debouncer that emits a one-cycle change event with a change mask.
module sw_debounce_24 #(
  parameter int WIDTH        = 24,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [WIDTH-1:0] change_mask,
  output logic             sample_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q;
  logic             pre_wrap;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             chg_q, commit;

  assign pre_wrap = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d    = pre_wrap ? '0 : pre_q + 1'b1;

  // Debounce decision is only taken on the registered tick, one cycle after the wrap.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    mask_d   = mask_q;
    commit   = 1'b0;
    if (tick_q) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        cnt_d  = '0;
      end else if (cand_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
        commit   = 1'b1;
        stable_d = cand_q;
        mask_d   = stable_q ^ cand_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      mask_q   <= '0;
      chg_q    <= 1'b0;
    end else begin
      s1_q     <= sw_raw;
      s2_q     <= s1_q;
      pre_q    <= pre_d;
      tick_q   <= pre_wrap;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      chg_q    <= commit;
    end
  end

  assign sw_stable   = stable_q;
  assign sw_changed  = chg_q;
  assign change_mask = mask_q;
  assign sample_tick = tick_q;

endmodule
